// File: rtl/ysyx_23060025_prog_mux_key.sv
`default_nettype none
// ysyx_23060025_prog_mux_key: run-time programmable key->data table with a
// registered valid/ready lookup response and saturating miss counter. Rev 1.0
module ysyx_23060025_prog_mux_key #(
  parameter int NR_KEY      = 8,
  parameter int KEY_LEN     = 8,
  parameter int DATA_LEN    = 32,
  parameter int HAS_DEFAULT = 1,
  parameter int CNT_LEN     = 16,
  parameter int IDX_LEN     = $clog2(NR_KEY)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                wr_en_i,
  input  logic [IDX_LEN-1:0]  wr_idx_i,
  input  logic [KEY_LEN-1:0]  wr_key_i,
  input  logic [DATA_LEN-1:0] wr_data_i,
  input  logic                wr_vld_i,
  input  logic                clr_i,
  input  logic [DATA_LEN-1:0] default_out_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [KEY_LEN-1:0]  req_key_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [DATA_LEN-1:0] resp_data_o,
  output logic                resp_hit_o,
  output logic [IDX_LEN-1:0]  resp_idx_o,
  output logic [CNT_LEN-1:0]  miss_cnt_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, FULL = 1'b1} state_t;

  logic [NR_KEY-1:0]   vld_q;
  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];
  logic [NR_KEY-1:0]   wr_sel;
  logic [NR_KEY-1:0]   match;

  state_t              state_q;
  logic [DATA_LEN-1:0] resp_data_q;
  logic                resp_hit_q;
  logic [IDX_LEN-1:0]  resp_idx_q;
  logic [CNT_LEN-1:0]  miss_cnt_q;

  logic                accept;
  logic                lk_hit;
  logic [IDX_LEN-1:0]  lk_idx;
  logic [DATA_LEN-1:0] lk_data;

  // Out-of-range wr_idx (non-power-of-2 tables) selects no entry.
  generate
    for (genvar i = 0; i < NR_KEY; i++) begin : g_entry
      assign wr_sel[i] = wr_en_i && (wr_idx_i == IDX_LEN'(i));
      assign match[i]  = vld_q[i] && (key_q[i] == req_key_i);
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q <= '0;
      for (int i = 0; i < NR_KEY; i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (clr_i) begin
      vld_q <= '0;
    end else begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (wr_sel[i]) begin
          vld_q[i]  <= wr_vld_i;
          key_q[i]  <= wr_key_i;
          data_q[i] <= wr_data_i;
        end
      end
    end
  end

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = '0;
    lk_data = (HAS_DEFAULT != 0) ? default_out_i : '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (match[i]) begin
        lk_hit  = 1'b1;
        lk_idx  = IDX_LEN'(i);
        lk_data = data_q[i];
      end
    end
  end

  assign req_ready_o = (state_q == IDLE) || resp_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      resp_data_q <= '0;
      resp_hit_q  <= 1'b0;
      resp_idx_q  <= '0;
      miss_cnt_q  <= '0;
    end else begin
      if (accept) begin
        state_q     <= FULL;
        resp_data_q <= lk_data;
        resp_hit_q  <= lk_hit;
        resp_idx_q  <= lk_idx;
        if (!lk_hit && (miss_cnt_q != '1)) begin
          miss_cnt_q <= miss_cnt_q + CNT_LEN'(1);
        end
      end else if (resp_ready_i) begin
        state_q <= IDLE;
      end
    end
  end

  assign resp_valid_o = (state_q == FULL);
  assign resp_data_o  = resp_data_q;
  assign resp_hit_o   = resp_hit_q;
  assign resp_idx_o   = resp_idx_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule
`default_nettype wire
